stopwatch_digit_counter: RTL and testbench

STOPWATCH_DIGIT_COUNTER -- requirements
Module: stopwatch_digit_counter

---
 rtl/stopwatch_digit_counter_if.sv | 14 +
 rtl/stopwatch_digit_counter.sv | 42 ++++
 tb/tb_stopwatch_digit_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_digit_counter_if.sv
// stopwatch_digit_counter_if: control, load and status signals of one counter digit
interface stopwatch_digit_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic             mode;
    logic             load;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             trg;
    logic             ovr;
    modport master (output en, mode, load, clr, d, input q, tc, trg, ovr);
    modport slave  (input en, mode, load, clr, d, output q, tc, trg, ovr);
endinterface

// File: rtl/stopwatch_digit_counter.sv
// stopwatch_digit_counter: modulo-MODULUS up/down digit with load, clear,
// combinational carry/borrow (tc) for cascading and a registered wrap pulse.
module stopwatch_digit_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    stopwatch_digit_counter_if.slave bus
);
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("stopwatch_digit_counter: MODULUS must be in 2..2**WIDTH");
    end
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] nxt;
    logic             over;
    assign over   = bus.d > MAX;
    assign bus.tc = bus.en & (bus.mode ? bus.q == MAX : bus.q == '0);
    // explicit compare-and-wrap so non-power-of-two moduli never see binary overflow
    assign nxt = bus.mode ? (bus.q == MAX ? '0 : bus.q + 1'b1)
                          : (bus.q == '0 ? MAX : bus.q - 1'b1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.q   <= '0;
            bus.trg <= 1'b0;
            bus.ovr <= 1'b0;
        end else if (bus.clr) begin
            bus.q   <= '0;
            bus.trg <= 1'b0;
            bus.ovr <= 1'b0;
        end else if (bus.load) begin
            bus.q   <= over ? MAX : bus.d;
            bus.trg <= 1'b0;
            bus.ovr <= bus.ovr | over;
        end else if (bus.en) begin
            bus.q   <= nxt;
            bus.trg <= bus.tc;
        end else begin
            bus.trg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stopwatch_digit_counter.sv
// tb_stopwatch_digit_counter: directed checks of single digits (mod 6, 10, 2)
// and a two-digit mod-60 cascade.
module tb_stopwatch_digit_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   trg_cnt;
    always #5 clk = ~clk;
    stopwatch_digit_counter_if #(.WIDTH(4)) if6 ();
    stopwatch_digit_counter_if #(.WIDTH(4)) if10 ();
    stopwatch_digit_counter_if #(.WIDTH(4)) if2 ();
    stopwatch_digit_counter_if #(.WIDTH(4)) ifl ();
    stopwatch_digit_counter_if #(.WIDTH(4)) ifh ();
    stopwatch_digit_counter #(.MODULUS(6),  .WIDTH(4)) u6  (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
    stopwatch_digit_counter #(.MODULUS(10), .WIDTH(4)) u10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave));
    stopwatch_digit_counter #(.MODULUS(2),  .WIDTH(4)) u2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    stopwatch_digit_counter #(.MODULUS(10), .WIDTH(4)) ulo (.clk(clk), .rst_n(rst_n), .bus(ifl.slave));
    stopwatch_digit_counter #(.MODULUS(6),  .WIDTH(4)) uhi (.clk(clk), .rst_n(rst_n), .bus(ifh.slave));
    assign ifh.en = ifl.tc;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {if6.en, if6.mode, if6.load, if6.clr, if6.d} = '0;
        {if10.en, if10.mode, if10.load, if10.clr, if10.d} = '0;
        {if2.en, if2.mode, if2.load, if2.clr, if2.d} = '0;
        {ifl.en, ifl.mode, ifl.load, ifl.clr, ifl.d} = '0;
        {ifh.mode, ifh.load, ifh.clr, ifh.d} = '0;
        if6.en = 1'b1;
        if10.en = 1'b1;
        if10.mode = 1'b1;
        #3;
        chk("rst_q", int'(if6.q), 0);
        chk("rst_trg", int'(if6.trg), 0);
        chk("rst_ovr", int'(if6.ovr), 0);
        chk("rst_tc_down", int'(if6.tc), 1);
        chk("rst_tc_up", int'(if10.tc), 0);
        if6.en = 1'b0;
        if10.en = 1'b0;
        if10.mode = 1'b0;
        #9 rst_n = 1'b1;
        // up-wrap mod 6
        if6.mode = 1'b1;
        if6.en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("up6_q%0d", i), int'(if6.q), i % 6);
            chk($sformatf("up6_tc%0d", i), int'(if6.tc), (i % 6 == 5) ? 1 : 0);
            chk($sformatf("up6_trg%0d", i), int'(if6.trg), (i == 6) ? 1 : 0);
        end
        if6.en = 1'b0;
        // illegal load, sticky ovr, clear
        if6.load = 1'b1; if6.d = 4'd12;
        tick();
        chk("ill_q", int'(if6.q), 5);
        chk("ill_ovr", int'(if6.ovr), 1);
        if6.d = 4'd2;
        tick();
        chk("legal_q", int'(if6.q), 2);
        chk("legal_ovr_sticky", int'(if6.ovr), 1);
        if6.load = 1'b0; if6.clr = 1'b1;
        tick();
        chk("clr_q", int'(if6.q), 0);
        chk("clr_ovr", int'(if6.ovr), 0);
        chk("clr_trg", int'(if6.trg), 0);
        if6.clr = 1'b0; if6.load = 1'b1; if6.d = 4'd5;
        tick();
        chk("load05_q", int'(if6.q), 5);
        chk("load05_trg", int'(if6.trg), 0);
        chk("load05_ovr", int'(if6.ovr), 0);
        if6.load = 1'b0; if6.clr = 1'b1;
        tick();
        chk("clr50_q", int'(if6.q), 0);
        chk("clr50_trg", int'(if6.trg), 0);
        // priority
        if6.load = 1'b1; if6.d = 4'd3; if6.en = 1'b1; if6.mode = 1'b1;
        tick();
        chk("prio_clr_q", int'(if6.q), 0);
        if6.clr = 1'b0;
        tick();
        chk("prio_load_q", int'(if6.q), 3);
        if6.load = 1'b0;
        tick();
        chk("prio_count_q", int'(if6.q), 4);
        if6.en = 1'b0;
        tick();
        chk("hold_q", int'(if6.q), 4);
        // down-wrap mod 10
        if10.load = 1'b1; if10.d = 4'd0;
        tick();
        chk("dn10_load_q", int'(if10.q), 0);
        if10.load = 1'b0; if10.mode = 1'b0; if10.en = 1'b1;
        #1;
        chk("dn10_tc_at0", int'(if10.tc), 1);
        tick();
        chk("dn10_q9", int'(if10.q), 9);
        chk("dn10_trg", int'(if10.trg), 1);
        chk("dn10_tc_at9", int'(if10.tc), 0);
        tick();
        chk("dn10_q8", int'(if10.q), 8);
        chk("dn10_trg_once", int'(if10.trg), 0);
        // mode change takes effect on the next edge
        if10.mode = 1'b1;
        tick();
        chk("mode_up_q", int'(if10.q), 9);
        chk("mode_up_tc", int'(if10.tc), 1);
        if10.mode = 1'b0;
        #1;
        chk("mode_dn_tc", int'(if10.tc), 0);
        tick();
        chk("mode_dn_q", int'(if10.q), 8);
        chk("mode_dn_trg", int'(if10.trg), 0);
        if10.en = 1'b0;
        // mod 2: wrap pulse follows every 1->0 edge
        if2.mode = 1'b1; if2.en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("m2_q%0d", i), int'(if2.q), i % 2);
            chk($sformatf("m2_trg%0d", i), int'(if2.trg), (i % 2 == 0) ? 1 : 0);
        end
        if2.mode = 1'b0;
        tick();
        chk("m2_dn_q", int'(if2.q), 1);
        chk("m2_dn_trg", int'(if2.trg), 1);
        if2.en = 1'b0;
        // async reset mid-count, with a wrap pending on u10
        if6.load = 1'b1; if6.d = 4'd13;
        if10.load = 1'b1; if10.d = 4'd9;
        tick();
        chk("pre_rst_ovr", int'(if6.ovr), 1);
        if6.d = 4'd4;
        tick();
        chk("pre_rst_q", int'(if6.q), 4);
        if6.load = 1'b0; if6.mode = 1'b1; if6.en = 1'b1;
        if10.load = 1'b0; if10.mode = 1'b1; if10.en = 1'b1;
        #1;
        chk("pre_rst_tc10", int'(if10.tc), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_q", int'(if6.q), 0);
        chk("arst_ovr", int'(if6.ovr), 0);
        chk("arst_trg", int'(if6.trg), 0);
        chk("arst_q10", int'(if10.q), 0);
        chk("arst_tc_up", int'(if6.tc), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_q", int'(if6.q), 1);
        chk("post_rst_trg", int'(if6.trg), 0);
        chk("post_rst_q10", int'(if10.q), 1);
        chk("post_rst_trg10", int'(if10.trg), 0);
        if6.en = 1'b0;
        if10.en = 1'b0;
        // cascade mod 10 under mod 6
        ifl.mode = 1'b1; ifh.mode = 1'b1; ifl.en = 1'b1;
        trg_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            trg_cnt += int'(ifh.trg);
            chk($sformatf("cas_lo%0d", i), int'(ifl.q), i % 10);
            chk($sformatf("cas_hi%0d", i), int'(ifh.q), (i / 10) % 6);
        end
        chk("cas_hi_trg60", int'(ifh.trg), 1);
        chk("cas_hi_trg_count", trg_cnt, 1);
        tick();
        chk("cas_hi_trg61", int'(ifh.trg), 0);
        chk("cas_lo61", int'(ifl.q), 1);
        ifl.en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
